// File: rtl/ram_pkg.sv
// Shared constants for the dual-port RAM: read-during-write modes and init FSM encoding.
package ram_pkg;

    localparam int unsigned RDW_READ_FIRST  = 0;
    localparam int unsigned RDW_WRITE_FIRST = 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/ram_init_ctrl.sv
// Init sequencer: walks every address once after reset, then hands the write port to the user.
module ram_init_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              init_we_c,
    output logic [ADDR_W-1:0] init_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    // State, counter and busy flag; busy tracks the next state so it drops with the last init write
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= (state_d == ST_INIT);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_we_c = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we_c = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign init_addr = cnt_q;

endmodule

// File: rtl/param_dual_port_ram.sv
// Simple dual-port RAM (one write, one read port) with self-initialisation and selectable read-during-write.
module param_dual_port_ram
    import ram_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 4,
    parameter int unsigned       RDW_MODE = RDW_READ_FIRST,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] din,
    input  logic              re,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              busy
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              init_we_c;
    logic [ADDR_W-1:0] init_addr;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              rd_en_c;
    logic              rdw_hit_c;

    ram_init_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_init_ctrl (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .init_we_c (init_we_c),
        .init_addr (init_addr)
    );

    // Write-port mux: the init sequencer owns the port while busy; nothing is written during reset
    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = write_addr;
        mem_wdata_c = din;
        if (busy) begin
            mem_we_c    = rst && init_we_c;
            mem_waddr_c = init_addr;
            mem_wdata_c = INIT_VAL;
        end else begin
            mem_we_c = rst && we;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign rd_en_c   = re && !busy;
    assign rdw_hit_c = (RDW_MODE == RDW_WRITE_FIRST) && we && (write_addr == read_addr);

    // Registered read port; write-first bypasses din on an address collision
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_en_c;
            if (rd_en_c) begin
                dout <= rdw_hit_c ? din : mem[read_addr];
            end
        end
    end

endmodule
